fifo_rd_stream: RTL

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_stream_pkg.sv | 21 ++
 rtl/fifo_skid_buf.sv | 73 +++++++
 rtl/fifo_rd_stream.sv | 80 ++++++++
 3 files changed

// File: rtl/fifo_stream_pkg.sv
// Shared types and constants for the FIFO read-side streaming block.
package fifo_stream_pkg;

  localparam int unsigned SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  function automatic logic [1:0] occ_count(input occ_e s);
    case (s)
      EMPTY:   return 2'd0;
      ONE:     return 2'd1;
      TWO:     return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order skid buffer; head entry drives the output register directly.
module fifo_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int unsigned SIZE = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic [SIZE-1:0] push_data_i,
  input  logic            pop_i,
  output logic            valid_o,
  output logic [SIZE-1:0] data_o,
  output occ_e            state_o
);

  occ_e            state_q, state_d;
  logic [SIZE-1:0] head_q, head_d;
  logic [SIZE-1:0] tail_q, tail_d;
  logic            pop;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    pop     = (state_q != EMPTY) && pop_i;
    unique case (state_q)
      EMPTY: begin
        if (push_i) begin
          head_d  = push_data_i;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push_i && pop) begin
          head_d = push_data_i;
        end else if (push_i) begin
          tail_d  = push_data_i;
          state_d = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // Push is never offered here: the issuer reserves space before reading.
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush_i) state_d = EMPTY;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign valid_o = (state_q != EMPTY);
  assign data_o  = head_q;
  assign state_o = state_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Turns a FIFO read port into a valid/ready stream: read issue, in-flight
// tracking, flush and transfer counting around a two-entry skid buffer.
module fifo_rd_stream
  import fifo_stream_pkg::*;
#(
  parameter int unsigned SIZE  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [SIZE-1:0]  fifo_dout_i,
  input  logic             fifo_empty_i,
  output logic             fifo_ren_o,
  input  logic             flush_i,
  output logic             m_valid_o,
  output logic [SIZE-1:0]  m_data_o,
  input  logic             m_ready_i,
  output logic [CNT_W-1:0] xfer_count_o
);

  localparam logic [2:0] DEPTH = 3'(SKID_DEPTH);

  logic             ren_q, ren_d;
  logic             inflight_q, inflight_d;
  logic             started_q, started_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       accept, capture, xfer;
  logic [1:0] occ_now;
  logic [2:0] occ_after, demand;
  occ_e       occ_state;

  always_comb begin
    accept     = ren_q && !fifo_empty_i;
    capture    = inflight_q && !flush_i;
    xfer       = m_valid_o && m_ready_i;
    occ_now    = occ_count(occ_state);
    occ_after  = flush_i ? 3'd0
                         : ({1'b0, occ_now} + {2'b0, capture} - {2'b0, xfer});
    inflight_d = accept && !flush_i;
    // The read requested now lands two edges later and downstream may stall
    // meanwhile, so space is reserved for everything already committed.
    demand     = occ_after + {2'b0, inflight_d} + 3'd1;
    ren_d      = started_q && !fifo_empty_i && !flush_i && (demand <= DEPTH);
    started_d  = 1'b1;
    cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, xfer};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ren_q      <= 1'b0;
      inflight_q <= 1'b0;
      started_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      ren_q      <= ren_d;
      inflight_q <= inflight_d;
      started_q  <= started_d;
      cnt_q      <= cnt_d;
    end
  end

  fifo_skid_buf #(
    .SIZE(SIZE)
  ) u_skid (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .flush_i    (flush_i),
    .push_i     (capture),
    .push_data_i(fifo_dout_i),
    .pop_i      (m_ready_i),
    .valid_o    (m_valid_o),
    .data_o     (m_data_o),
    .state_o    (occ_state)
  );

  assign fifo_ren_o   = ren_q;
  assign xfer_count_o = cnt_q;

endmodule
